// File: rtl/kp_scanner.sv
// kp_scanner -- 4x4 keypad column drive / row sense front end.
//
// Strobes one keypad column low at a time and reads the four rows back
// through a two-flop synchronizer. A non-idle row pattern seen at the end of
// a column slot is captured and must hold for DEBOUNCE_CYCLES consecutive
// samples before it is accepted as a press. An all-high pattern must then
// hold for DEBOUNCE_CYCLES samples before it is accepted as a release. The
// downstream decoder receives the frozen column and the captured rows as an
// active-low {kpc, kpr} pair.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   kpr_in[3:0]  raw keypad rows, active-low, asynchronous to clk
//   kpc[3:0]     column drive, active-low, exactly one bit low
//   kpr[3:0]     debounced captured rows, active-low, 4'hF when idle
//   key_valid    high while a debounced key is held
//   key_press    one-cycle pulse on an accepted press
//   key_release  one-cycle pulse on an accepted release
module kp_scanner #(
  parameter int SCAN_DIV        = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] kpr_in,
  output logic [3:0] kpc,
  output logic [3:0] kpr,
  output logic       key_valid,
  output logic       key_press,
  output logic       key_release
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]       ROWS_IDLE = 4'hF;
  localparam logic [3:0]       COL_FIRST = 4'b0111;

  typedef enum logic [1:0] {
    ST_SCAN       = 2'd0,
    ST_DEBOUNCE   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } state_t;

  // Column rotation. Any pattern that is not a legal one-hot-low column
  // restarts at column 0 so the drive can never stay stuck on an illegal value.
  function automatic logic [3:0] next_col(input logic [3:0] col);
    logic [3:0] nxt;
    case (col)
      4'b0111: nxt = 4'b1011;
      4'b1011: nxt = 4'b1101;
      4'b1101: nxt = 4'b1110;
      4'b1110: nxt = 4'b0111;
      default: nxt = COL_FIRST;
    endcase
    return nxt;
  endfunction

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_sync1, r_rs;
  logic [DIV_W-1:0] r_div_cnt, w_div_nxt;
  logic [DB_W-1:0]  r_db_cnt, w_db_nxt;
  logic [3:0]       r_cap, w_cap_nxt;
  logic [3:0]       r_kpc, w_kpc_nxt;
  logic [3:0]       r_kpr, w_kpr_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_press, w_press_nxt;
  logic             r_release, w_release_nxt;

  // Synchronizer resets to the idle (all-high) pattern so a key still held
  // through reset is only seen again once the scan reaches its column.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= ROWS_IDLE;
      r_rs    <= ROWS_IDLE;
    end else begin
      r_sync1 <= kpr_in;
      r_rs    <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_SCAN;
      r_div_cnt <= '0;
      r_db_cnt  <= '0;
      r_cap     <= ROWS_IDLE;
      r_kpc     <= COL_FIRST;
      r_kpr     <= ROWS_IDLE;
      r_valid   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_div_cnt <= w_div_nxt;
      r_db_cnt  <= w_db_nxt;
      r_cap     <= w_cap_nxt;
      r_kpc     <= w_kpc_nxt;
      r_kpr     <= w_kpr_nxt;
      r_valid   <= w_valid_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_div_nxt     = r_div_cnt;
    w_db_nxt      = r_db_cnt;
    w_cap_nxt     = r_cap;
    w_kpc_nxt     = r_kpc;
    w_kpr_nxt     = r_kpr;
    w_valid_nxt   = r_valid;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;

    case (r_state)
      ST_SCAN: begin
        // Rows are only trusted at the end of a column slot, after the
        // synchronizer and the keypad lines have settled on the new column.
        if (r_div_cnt == DIV_LAST) begin
          w_div_nxt = '0;
          if (r_rs == ROWS_IDLE) begin
            w_kpc_nxt = next_col(r_kpc);
          end else begin
            w_cap_nxt   = r_rs;
            w_db_nxt    = '0;
            w_state_nxt = ST_DEBOUNCE;
          end
        end else begin
          w_div_nxt = r_div_cnt + DIV_W'(1);
        end
      end

      ST_DEBOUNCE: begin
        if (r_rs == r_cap) begin
          if (r_db_cnt == DB_LAST) begin
            w_state_nxt = ST_HELD;
            w_db_nxt    = '0;
            w_kpr_nxt   = r_cap;
            w_valid_nxt = 1'b1;
            w_press_nxt = 1'b1;
          end else begin
            w_db_nxt = r_db_cnt + DB_W'(1);
          end
        end else begin
          // Bounce or a different pattern: give up on this column quietly.
          w_state_nxt = ST_SCAN;
          w_kpc_nxt   = next_col(r_kpc);
          w_div_nxt   = '0;
          w_db_nxt    = '0;
        end
      end

      ST_HELD: begin
        // Only a full release matters; extra keys or pattern changes while
        // held leave the captured pattern in place.
        if (r_rs == ROWS_IDLE) begin
          w_state_nxt = ST_RELEASE_DB;
          w_db_nxt    = '0;
        end
      end

      ST_RELEASE_DB: begin
        if (r_rs == ROWS_IDLE) begin
          if (r_db_cnt == DB_LAST) begin
            w_state_nxt   = ST_SCAN;
            w_db_nxt      = '0;
            w_div_nxt     = '0;
            w_kpc_nxt     = next_col(r_kpc);
            w_kpr_nxt     = ROWS_IDLE;
            w_valid_nxt   = 1'b0;
            w_release_nxt = 1'b1;
          end else begin
            w_db_nxt = r_db_cnt + DB_W'(1);
          end
        end else begin
          w_state_nxt = ST_HELD;
          w_db_nxt    = '0;
        end
      end

      default: begin
        w_state_nxt = ST_SCAN;
        w_div_nxt   = '0;
        w_db_nxt    = '0;
        w_kpc_nxt   = COL_FIRST;
        w_kpr_nxt   = ROWS_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign kpc         = r_kpc;
  assign kpr         = r_kpr;
  assign key_valid   = r_valid;
  assign key_press   = r_press;
  assign key_release = r_release;

endmodule

// File: tb/tb_kp_scanner.sv
// Directed bench for kp_scanner (SCAN_DIV=8, DEBOUNCE_CYCLES=16).
// Keypad model: one key at column 1011; its row pattern (key_row) is driven
// onto kpr_in only while that column is strobed low and the contact is closed.
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
// Per cycle the packed vector {kpc, kpr, key_valid, key_press, key_release}
// is compared against a hand-derived expectation.
module tb_kp_scanner;

  logic       clk;
  logic       reset;
  logic [3:0] kpr_in;
  logic [3:0] kpc;
  logic [3:0] kpr;
  logic       key_valid;
  logic       key_press;
  logic       key_release;

  logic       contact;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic [3:0] cols [4];

  int checks;
  int failures;

  kp_scanner #(.SCAN_DIV(8), .DEBOUNCE_CYCLES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .kpr_in     (kpr_in),
    .kpc        (kpc),
    .kpr        (kpr),
    .key_valid  (key_valid),
    .key_press  (key_press),
    .key_release(key_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign kpr_in = (contact && (kpc == key_col)) ? key_row : 4'hF;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // Reset state with the key open.
  task automatic test_reset;
    logic [10:0] got, exp;
    reset = 1'b1;
    contact = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got = {kpc, kpr, key_valid, key_press, key_release};
    exp = {4'b0111, 4'hF, 3'b000};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL reset: got {kpc,kpr,v,p,r}=%b exp=%b", got, exp);
    end
    reset = 1'b0;
  endtask

  // Idle scan: column advances every 8 clocks, wrapping after 1110.
  task automatic test_idle_scan;
    logic [10:0] got, exp;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      got = {kpc, kpr, key_valid, key_press, key_release};
      exp = {cols[(n / 8) % 4], 4'hF, 3'b000};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL idle_scan n=%0d: got %b exp=%b", n, got, exp);
      end
    end
  endtask

  // Clean press: column 1011 is driven with div reset; the sampling edge is
  // n=8, 16 matching samples follow, HELD (and key_press) after edge n=24.
  task automatic test_clean_press;
    logic [10:0] got, exp;
    contact = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      got = {kpc, kpr, key_valid, key_press, key_release};
      if (n >= 24) exp = {4'b1011, 4'b0111, 1'b1, (n == 24), 1'b0};
      else         exp = {4'b1011, 4'hF, 3'b000};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL clean_press n=%0d: got %b exp=%b", n, got, exp);
      end
    end
  endtask

  // A second row in the same column while held is ignored.
  task automatic test_second_row;
    logic [10:0] got, exp;
    exp = {4'b1011, 4'b0111, 3'b100};
    key_row = 4'b0011;
    for (int n = 1; n <= 54; n++) begin
      @(posedge clk); #1;
      got = {kpc, kpr, key_valid, key_press, key_release};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL second_row n=%0d: got %b exp=%b", n, got, exp);
      end
      if (n == 50) key_row = 4'b0111;
    end
  endtask

  // Release with three 4-clock bounces. Final opening after edge 24 reaches
  // the synchronized rows at edge 26; release pulse after edge 43 (17 later),
  // with the column advanced to 1101.
  task automatic test_bouncy_release;
    logic [10:0] got, exp;
    contact = 1'b0;
    for (int n = 1; n <= 46; n++) begin
      @(posedge clk); #1;
      got = {kpc, kpr, key_valid, key_press, key_release};
      if (n < 43) exp = {4'b1011, 4'b0111, 3'b100};
      else        exp = {4'b1101, 4'hF, 2'b00, (n == 43)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL bouncy_release n=%0d: got %b exp=%b", n, got, exp);
      end
      contact = ((n >= 4) && (n < 8)) || ((n >= 12) && (n < 16)) ||
                ((n >= 20) && (n < 24));
    end
  endtask

  // Bouncy press. Scan runs until column 1011 is driven again (21 clocks),
  // then the contact toggles every 5 clocks from n=2 to n=31 and stays closed.
  // Sample at n=8 catches a closed contact, the bounce aborts at n=10
  // (column -> 1101); the next pass samples at n=42 and presses at n=58.
  task automatic test_bouncy_press;
    logic [10:0] got, exp;
    logic [3:0]  ecol;
    for (int n = 1; n <= 21; n++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (kpc !== 4'b1011) begin
      failures++;
      $display("FAIL bouncy_press_align: got kpc=%b exp=1011", kpc);
    end
    for (int n = 1; n <= 70; n++) begin
      @(posedge clk); #1;
      if (n < 10)      ecol = 4'b1011;
      else if (n < 18) ecol = 4'b1101;
      else if (n < 26) ecol = 4'b1110;
      else if (n < 34) ecol = 4'b0111;
      else             ecol = 4'b1011;
      got = {kpc, kpr, key_valid, key_press, key_release};
      if (n >= 58) exp = {ecol, 4'b0111, 1'b1, (n == 58), 1'b0};
      else         exp = {ecol, 4'hF, 3'b000};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL bouncy_press n=%0d: got %b exp=%b", n, got, exp);
      end
      contact = ((n >= 2) && (n < 7)) || ((n >= 12) && (n < 17)) ||
                ((n >= 22) && (n < 27)) || (n >= 32);
    end
  endtask

  // One-cycle reset while held: no release pulse; the still-held key is
  // found on the next pass (column 1011 at n=8, sample at n=16, press at n=32).
  task automatic test_reset_mid_held;
    logic [10:0] got, exp;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    got = {kpc, kpr, key_valid, key_press, key_release};
    exp = {4'b0111, 4'hF, 3'b000};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL reset_mid_held: got %b exp=%b", got, exp);
    end
    for (int n = 1; n <= 36; n++) begin
      @(posedge clk); #1;
      got = {kpc, kpr, key_valid, key_press, key_release};
      if (n >= 32)     exp = {4'b1011, 4'b0111, 1'b1, (n == 32), 1'b0};
      else if (n >= 8) exp = {4'b1011, 4'hF, 3'b000};
      else             exp = {4'b0111, 4'hF, 3'b000};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL redetect n=%0d: got %b exp=%b", n, got, exp);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cols[0]  = 4'b0111;
    cols[1]  = 4'b1011;
    cols[2]  = 4'b1101;
    cols[3]  = 4'b1110;
    key_col  = 4'b1011;
    key_row  = 4'b0111;
    contact  = 1'b0;
    reset    = 1'b1;
    test_reset();
    test_idle_scan();
    test_clean_press();
    test_second_row();
    test_bouncy_release();
    test_bouncy_press();
    test_reset_mid_held();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
